// File: rtl/dmem_responder.sv
// rtl/dmem_responder.sv - data-memory slave: word RAM, LED/TX-FIFO/cycle-counter MMIO window
module dmem_responder #(
    parameter int              XLEN        = 32,
    parameter int              ALEN        = 32,
    parameter int              DEPTH_WORDS = 4096,
    parameter logic [ALEN-1:0] MMIO_BASE   = 32'h8000_0000,
    parameter int              TX_DEPTH    = 8
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [ALEN-1:0] dmem_addr,
    input  logic [XLEN-1:0] dmem_wdata,
    input  logic            dmem_we,
    input  logic [3:0]      dmem_be,
    input  logic [2:0]      dmem_funct3,
    output logic [XLEN-1:0] dmem_rdata,
    output logic            tx_valid,
    output logic [7:0]      tx_data,
    input  logic            tx_ready,
    output logic [7:0]      led_out
);
    localparam int              IW        = $clog2(DEPTH_WORDS);
    localparam int              AW        = $clog2(TX_DEPTH);
    localparam int              CW        = AW + 1;
    localparam logic [ALEN-1:0] RAM_BYTES = ALEN'(DEPTH_WORDS * 4);

    logic            ram_sel, mmio_sel;
    logic [2:0]      mmio_off;
    logic [IW-1:0]   ram_idx;
    logic [XLEN-1:0] ram_q [DEPTH_WORDS];

    logic [7:0]      tx_mem_q [TX_DEPTH];
    logic [CW-1:0]   rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d, count;
    logic            full, empty, push_req, push_ok, pop;
    logic            ovf_q, ovf_d;
    logic [7:0]      led_q, led_d;
    logic [63:0]     cycle_q;

    logic [XLEN-1:0] raw, status;
    logic [7:0]      rbyte;
    logic [15:0]     rhalf;

    assign ram_sel  = dmem_addr < RAM_BYTES;
    assign mmio_sel = dmem_addr[ALEN-1:5] == MMIO_BASE[ALEN-1:5];
    assign mmio_off = dmem_addr[4:2];
    assign ram_idx  = dmem_addr[IW+1:2];

    always_ff @(posedge clk) begin
        if (dmem_we && ram_sel) begin
            for (int i = 0; i < 4; i++) begin
                if (dmem_be[i]) ram_q[ram_idx][8*i +: 8] <= dmem_wdata[8*i +: 8];
            end
        end
    end

    assign count    = wr_ptr_q - rd_ptr_q;
    assign full     = count == CW'(TX_DEPTH);
    assign empty    = count == '0;
    assign tx_valid = !empty;
    assign tx_data  = tx_mem_q[rd_ptr_q[AW-1:0]];
    assign pop      = tx_valid && tx_ready;
    assign push_req = dmem_we && mmio_sel && (mmio_off == 3'd1) && dmem_be[0];
    // When full, a simultaneous pop frees the slot the push lands in.
    assign push_ok  = push_req && (!full || pop);
    assign led_out  = led_q;

    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        ovf_d    = ovf_q;
        led_d    = led_q;
        if (pop)     rd_ptr_d = rd_ptr_q + 1'b1;
        if (push_ok) wr_ptr_d = wr_ptr_q + 1'b1;
        if (dmem_we && mmio_sel && (mmio_off == 3'd2) && dmem_wdata[2]) ovf_d = 1'b0;
        if (push_req && !push_ok) ovf_d = 1'b1;
        if (dmem_we && mmio_sel && (mmio_off == 3'd0) && dmem_be[0]) led_d = dmem_wdata[7:0];
    end

    always_ff @(posedge clk) begin
        if (push_ok) tx_mem_q[wr_ptr_q[AW-1:0]] <= dmem_wdata[7:0];
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            ovf_q    <= 1'b0;
            led_q    <= '0;
            cycle_q  <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            ovf_q    <= ovf_d;
            led_q    <= led_d;
            cycle_q  <= cycle_q + 64'd1;
        end
    end

    always_comb begin
        status         = '0;
        status[8 +: CW] = count;
        status[2]      = ovf_q;
        status[1]      = empty;
        status[0]      = full;
        raw            = '0;
        if (ram_sel) begin
            raw = ram_q[ram_idx];
        end else if (mmio_sel) begin
            case (mmio_off)
                3'd0:    raw = XLEN'(led_q);
                3'd2:    raw = status;
                3'd3:    raw = cycle_q[31:0];
                3'd4:    raw = cycle_q[63:32];
                default: raw = '0;
            endcase
        end
    end

    assign rbyte = raw[8*dmem_addr[1:0] +: 8];
    assign rhalf = raw[16*dmem_addr[1] +: 16];

    always_comb begin
        case (dmem_funct3)
            3'b000:  dmem_rdata = {{(XLEN-8){rbyte[7]}}, rbyte};
            3'b001:  dmem_rdata = {{(XLEN-16){rhalf[15]}}, rhalf};
            3'b100:  dmem_rdata = {{(XLEN-8){1'b0}}, rbyte};
            3'b101:  dmem_rdata = {{(XLEN-16){1'b0}}, rhalf};
            default: dmem_rdata = raw;
        endcase
    end
endmodule

// File: tb/tb_dmem_responder.sv
// tb/tb_dmem_responder.sv - directed self-checking bench for dmem_responder
module tb_dmem_responder;
    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
    logic        dmem_we;
    logic [3:0]  dmem_be;
    logic [2:0]  dmem_funct3;
    logic        tx_valid, tx_ready;
    logic [7:0]  tx_data, led_out;

    int checks = 0;
    int errors = 0;

    localparam logic [31:0] LED_A = 32'h8000_0000;
    localparam logic [31:0] TXD_A = 32'h8000_0004;
    localparam logic [31:0] STA_A = 32'h8000_0008;
    localparam logic [31:0] CLO_A = 32'h8000_000C;
    localparam logic [31:0] CHI_A = 32'h8000_0010;

    dmem_responder dut (
        .clk(clk), .rst(rst), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
        .dmem_we(dmem_we), .dmem_be(dmem_be), .dmem_funct3(dmem_funct3),
        .dmem_rdata(dmem_rdata), .tx_valid(tx_valid), .tx_data(tx_data),
        .tx_ready(tx_ready), .led_out(led_out)
    );

    always #5 clk = ~clk;

    task automatic do_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
        dmem_addr = a; dmem_wdata = d; dmem_be = be; dmem_we = 1'b1; dmem_funct3 = 3'b010;
        @(posedge clk); #1;
        dmem_we = 1'b0;
    endtask

    task automatic do_read(input logic [31:0] a, input logic [2:0] f3, output logic [31:0] d);
        dmem_addr = a; dmem_funct3 = f3; dmem_we = 1'b0;
        #1;
        d = dmem_rdata;
    endtask

    task automatic test_reset();
        logic [31:0] r;
        do_read(STA_A, 3'b010, r);
        checks++; if (r !== 32'h2) begin errors++; $display("FAIL reset_status got %h exp %h", r, 32'h2); end
        checks++; if (tx_valid !== 1'b0) begin errors++; $display("FAIL reset_tx_valid got %b exp 0", tx_valid); end
        checks++; if (led_out !== 8'h0) begin errors++; $display("FAIL reset_led got %h exp 00", led_out); end
    endtask

    task automatic test_ram_loads();
        logic [31:0] r;
        logic [31:0] va [11] = '{32'h100, 32'h100, 32'h101, 32'h102, 32'h103, 32'h102, 32'h102, 32'h102, 32'h104, 32'h106, 32'h105};
        logic [2:0]  vf [11] = '{3'b010, 3'b000, 3'b000, 3'b001, 3'b100, 3'b000, 3'b100, 3'b101, 3'b001, 3'b101, 3'b011};
        logic [31:0] ve [11] = '{32'h11223344, 32'h44, 32'h33, 32'h1122, 32'h11,
                                 32'hFFFFFFFF, 32'hFF, 32'h11FF, 32'hFFFF8002, 32'h8001, 32'h80018002};
        do_write(32'h100, 32'h11223344, 4'b1111);
        do_write(32'h104, 32'h80018002, 4'b1111);
        for (int i = 0; i < 11; i++) begin
            if (i == 5) do_write(32'h100, 32'h00FF0000, 4'b0100);
            do_read(va[i], vf[i], r);
            checks++; if (r !== ve[i]) begin errors++; $display("FAIL ram_load[%0d] got %h exp %h", i, r, ve[i]); end
        end
    endtask

    task automatic test_same_cycle();
        do_write(32'h200, 32'hAAAAAAAA, 4'b1111);
        dmem_addr = 32'h200; dmem_wdata = 32'h55555555; dmem_be = 4'b1111; dmem_we = 1'b1; dmem_funct3 = 3'b010;
        #1;
        checks++; if (dmem_rdata !== 32'hAAAAAAAA) begin errors++; $display("FAIL same_cycle_old got %h exp aaaaaaaa", dmem_rdata); end
        @(posedge clk); #1;
        dmem_we = 1'b0;
        #1;
        checks++; if (dmem_rdata !== 32'h55555555) begin errors++; $display("FAIL same_cycle_new got %h exp 55555555", dmem_rdata); end
    endtask

    task automatic test_fifo();
        logic [31:0] r;
        tx_ready = 1'b0;
        dmem_addr = TXD_A; dmem_wdata = 32'h41; dmem_be = 4'b0001; dmem_we = 1'b1;
        #1;
        checks++; if (tx_valid !== 1'b0) begin errors++; $display("FAIL fifo_no_bypass got %b exp 0", tx_valid); end
        @(posedge clk); #1;
        dmem_we = 1'b0;
        do_write(TXD_A, 32'h42, 4'b0001);
        do_write(TXD_A, 32'h43, 4'b0001);
        checks++; if (tx_valid !== 1'b1 || tx_data !== 8'h41) begin errors++; $display("FAIL fifo_head got %b/%h exp 1/41", tx_valid, tx_data); end
        do_read(STA_A, 3'b010, r);
        checks++; if (r !== 32'h300) begin errors++; $display("FAIL fifo_status3 got %h exp 00000300", r); end
        do_read(TXD_A, 3'b010, r);
        checks++; if (r !== 32'h0) begin errors++; $display("FAIL txdata_read got %h exp 0", r); end
        tx_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            checks++; if (tx_valid !== 1'b1 || tx_data !== 8'(8'h41 + i)) begin errors++; $display("FAIL fifo_drain[%0d] got %b/%h exp 1/%h", i, tx_valid, tx_data, 8'(8'h41 + i)); end
            @(posedge clk); #1;
        end
        checks++; if (tx_valid !== 1'b0) begin errors++; $display("FAIL fifo_empty got %b exp 0", tx_valid); end
        tx_ready = 1'b0;
    endtask

    task automatic test_overflow();
        logic [31:0] r;
        logic [7:0]  exp_b [8] = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h77};
        tx_ready = 1'b0;
        for (int i = 0; i < 8; i++) do_write(TXD_A, 32'h30 + i, 4'b0001);
        do_read(STA_A, 3'b010, r);
        checks++; if (r !== 32'h801) begin errors++; $display("FAIL ovf_full got %h exp 00000801", r); end
        do_write(TXD_A, 32'h99, 4'b0001);
        do_read(STA_A, 3'b010, r);
        checks++; if (r !== 32'h805) begin errors++; $display("FAIL ovf_set got %h exp 00000805", r); end
        tx_ready = 1'b1;
        do_write(TXD_A, 32'h77, 4'b0001);
        tx_ready = 1'b0;
        do_read(STA_A, 3'b010, r);
        checks++; if (r !== 32'h805) begin errors++; $display("FAIL ovf_push_pop got %h exp 00000805", r); end
        do_write(STA_A, 32'h4, 4'b1111);
        do_read(STA_A, 3'b010, r);
        checks++; if (r !== 32'h801) begin errors++; $display("FAIL ovf_clear got %h exp 00000801", r); end
        tx_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            checks++; if (tx_valid !== 1'b1 || tx_data !== exp_b[i]) begin errors++; $display("FAIL ovf_drain[%0d] got %b/%h exp 1/%h", i, tx_valid, tx_data, exp_b[i]); end
            @(posedge clk); #1;
        end
        checks++; if (tx_valid !== 1'b0) begin errors++; $display("FAIL ovf_empty got %b exp 0", tx_valid); end
        tx_ready = 1'b0;
    endtask

    task automatic test_led_cycle();
        logic [31:0] r, c1, c2;
        do_write(LED_A, 32'h1A5, 4'b0001);
        checks++; if (led_out !== 8'hA5) begin errors++; $display("FAIL led_write got %h exp a5", led_out); end
        do_write(LED_A, 32'hFF00, 4'b0010);
        do_read(LED_A, 3'b010, r);
        checks++; if (r !== 32'hA5) begin errors++; $display("FAIL led_read got %h exp 000000a5", r); end
        do_read(CLO_A, 3'b010, c1);
        repeat (3) @(posedge clk);
        #1;
        do_read(CLO_A, 3'b010, c2);
        checks++; if (c2 - c1 !== 32'd3) begin errors++; $display("FAIL cycle_delta got %0d exp 3", c2 - c1); end
        do_read(CHI_A, 3'b010, r);
        checks++; if (r !== 32'h0) begin errors++; $display("FAIL cycle_hi got %h exp 0", r); end
    endtask

    task automatic test_unmapped();
        logic [31:0] r;
        do_write(32'h0, 32'h12345678, 4'b1111);
        do_read(32'h4000_0000, 3'b010, r);
        checks++; if (r !== 32'h0) begin errors++; $display("FAIL unmapped_read got %h exp 0", r); end
        do_write(32'h4000_0000, 32'hDEADBEEF, 4'b1111);
        do_write(32'h0000_4000, 32'hCAFEF00D, 4'b1111);
        do_write(32'h8000_0020, 32'h0000005A, 4'b1111);
        do_read(32'h0, 3'b010, r);
        checks++; if (r !== 32'h12345678) begin errors++; $display("FAIL unmapped_ram got %h exp 12345678", r); end
        checks++; if (led_out !== 8'hA5) begin errors++; $display("FAIL unmapped_led got %h exp a5", led_out); end
        do_read(32'h8000_0014, 3'b010, r);
        checks++; if (r !== 32'h0) begin errors++; $display("FAIL mmio_hole got %h exp 0", r); end
    endtask

    task automatic test_reset_mid();
        logic [31:0] r;
        tx_ready = 1'b0;
        do_write(TXD_A, 32'h61, 4'b0001);
        do_write(TXD_A, 32'h62, 4'b0001);
        checks++; if (tx_valid !== 1'b1) begin errors++; $display("FAIL pre_reset_valid got %b exp 1", tx_valid); end
        #2 rst = 1'b0;
        #1;
        checks++; if (tx_valid !== 1'b0 || led_out !== 8'h0) begin errors++; $display("FAIL async_reset got %b/%h exp 0/00", tx_valid, led_out); end
        do_read(CLO_A, 3'b010, r);
        checks++; if (r !== 32'h0) begin errors++; $display("FAIL reset_cycle got %h exp 0", r); end
        @(posedge clk); #1;
        rst = 1'b1;
        do_read(STA_A, 3'b010, r);
        checks++; if (r !== 32'h2) begin errors++; $display("FAIL post_reset_status got %h exp 00000002", r); end
    endtask

    initial begin
        rst = 1'b0; dmem_addr = '0; dmem_wdata = '0; dmem_we = 1'b0; dmem_be = '0;
        dmem_funct3 = 3'b010; tx_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        test_reset();
        rst = 1'b1;
        test_ram_loads();
        test_same_cycle();
        test_fifo();
        test_overflow();
        test_led_cycle();
        test_unmapped();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
- Slave end of the CPU data-memory interface. Answers dmem_addr / dmem_wdata / dmem_we / dmem_be / dmem_funct3 with dmem_rdata.
- Contains a word-organised data RAM with byte-lane writes and a small MMIO window: LED register, a console TX FIFO with a valid/ready byte stream, and a 64-bit cycle counter.
- Sits beside the pipelined core. Load data is returned combinationally in the same cycle as the MEM-stage request.

Parameters:
- XLEN, 32, data width
- ALEN, 32, address width
- DEPTH_WORDS, 4096, RAM depth in words (power of 2)
- MMIO_BASE, 32'h8000_0000, base of MMIO window; window is 32 bytes
- TX_DEPTH, 8, TX FIFO entries (power of 2, >=2)

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-low reset
- dmem_addr  in  ALEN  byte address
- dmem_wdata  in  XLEN  store data, already lane-aligned
- dmem_we  in  1  store strobe, one store per asserted cycle
- dmem_be  in  4  byte-lane enables for stores
- dmem_funct3  in  3  access type: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU
- dmem_rdata  out  XLEN  formatted load data, combinational
- tx_valid  out  1  TX FIFO head valid
- tx_data  out  8  TX FIFO head byte
- tx_ready  in  1  downstream accepts head byte
- led_out  out  8  LED register [7:0]

Behaviour:
- Address decode:
  - RAM when dmem_addr < DEPTH_WORDS*4; word index = addr[log2(DEPTH_WORDS)+1:2].
  - MMIO when addr[ALEN-1:5] == MMIO_BASE[ALEN-1:5].
  - Anything else is unmapped: reads return 0, writes are ignored.
- RAM store: on the rising clk edge with dmem_we=1, each lane i with be[i]=1 takes wdata[8i+7:8i]. The RAM is not reset.
- RAM/MMIO read: the raw word is selected combinationally. A store in the same cycle does not affect that cycle's read; it is visible from the next cycle.
- Load formatting is applied to all regions:
  - LB/LBU: byte addr[1:0], sign-/zero-extended.
  - LH/LHU: half addr[1], extended; addr[0] ignored.
  - LW: full word; addr[1:0] ignored.
  - Reserved funct3: full word.
- MMIO map (word offsets):
  - +0x00 LED: R/W. Lane 0 write updates led_out; reads return {24'b0, led}.
  - +0x04 TXDATA: write with be[0]=1 pushes wdata[7:0]. Read returns 0.
  - +0x08 STATUS: read returns {count[..] at bits[11:8], overflow bit2, empty bit1, full bit0}. A write with wdata[2]=1 clears overflow.
  - +0x0C CYCLE_LO and +0x10 CYCLE_HI: read-only. The counter increments every cycle and wraps at 2^64. A read of HI returns the live high word; no snapshot.
  - Other offsets read 0.
- TX FIFO:
  - Circular buffer, rd/wr pointers one bit wider than the index.
  - full = (count==TX_DEPTH); empty = (count==0).
  - tx_valid = !empty; tx_data = mem[rd_ptr].
  - Pop on tx_valid && tx_ready.
  - A push is accepted if !full, or if a pop occurs in the same cycle; count is then unchanged.
  - A push rejected when full sets sticky overflow. Overflow set and clear in the same cycle: set wins.
  - Pushes while empty are visible on tx_valid the next cycle; there is no bypass.
- Reset (rst=0, asynchronous): led_out=0, FIFO empty, tx_valid=0, overflow=0, cycle=0. dmem_rdata reflects the current combinational decode (RAM contents undefined). Reset mid-transfer discards FIFO contents.
- Latency: reads 0 cycles; writes and register updates take effect 1 cycle after the edge.

Test Plan:
- SW 0x11223344 @0x100 be=1111, then LW/LB/LBU/LH/LHU at 0x100..0x103 -> 0x11223344; LB@0x101=0x00000033; store 0xFF at byte 0x102 via be=0100 then LB@0x102=0xFFFFFFFF, LBU=0x000000FF, LHU@0x102=0x000011FF… verify per lane.
- Same-cycle SW+LW to 0x200 (old 0xAAAA_AAAA, new 0x5555_5555) -> rdata 0xAAAA_AAAA that cycle, 0x5555_5555 next.
- Push 'A','B','C' with tx_ready=0 -> tx_valid=1, tx_data=0x41, STATUS count=3; raise tx_ready -> 0x41, 0x42, 0x43 on consecutive cycles, then tx_valid=0.
- Fill 8 bytes, push a 9th with tx_ready=0 -> STATUS=0x0000_0805 (full, overflow), byte dropped. Push while full with tx_ready=1 -> accepted, count stays 8. Write STATUS 0x4 -> overflow cleared.
- Write LED 0x1A5 be=0001 -> led_out=0xA5. Read CYCLE_LO twice 3 cycles apart -> difference 3. Assert rst low mid-stream -> tx_valid=0, led_out=0 immediately (asynchronous).
- Unmapped read at 0x4000_0000 -> 0; a write there leaves RAM and MMIO unchanged.
